// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the Execute-stage multiply/divide unit:
// datapath width, M-extension funct3 codes and the unit's state encoding.
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = $clog2(XLEN + 1);

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [2:0] {
      MD_IDLE,
      MD_MUL,
      MD_DIV,
      MD_FIX,
      MD_DONE
   } md_state_t;

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the unsigned multiply/divide datapath on the 2*XLEN accumulator.
// Multiply: {hi,lo} with multiplier in lo. Divide: {remainder,quotient} with dividend in lo.
module muldiv_core
   import riscv_pkg::*;
(
   input  logic              divMode,
   input  logic [2*XLEN-1:0] accIn,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] accOut
);

   logic [XLEN:0]   addSum;
   logic [XLEN:0]   remShift;
   logic [XLEN-1:0] subLow;
   logic            canSub;

   // The trial remainder is always below 2*operand, so the low XLEN bits of the
   // difference are exact whenever the subtraction is taken.
   always_comb begin
      addSum   = {1'b0, accIn[2*XLEN-1:XLEN]} + (accIn[0] ? {1'b0, operand} : '0);
      remShift = accIn[2*XLEN-1:XLEN-1];
      canSub   = (remShift >= {1'b0, operand});
      subLow   = remShift[XLEN-1:0] - operand;
      if (!divMode) begin
         accOut = {addSum, accIn[XLEN-1:1]};
      end else if (canSub) begin
         accOut = {subLow, accIn[XLEN-2:0], 1'b1};
      end else begin
         accOut = {remShift[XLEN-1:0], accIn[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage. Stalls the pipeline via
// BusyE for XLEN steps plus a sign-fix cycle, then pulses DoneE with the result.
module ex_muldiv_unit
   import riscv_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   input  logic            StartE,
   input  logic [2:0]      FunctE,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [4:0]      RdE,
   input  logic            FlushE,
   output logic            BusyE,
   output logic            DoneE,
   output logic [XLEN-1:0] ResultE,
   output logic [4:0]      RdOutE
);

   md_state_t         state;
   logic [CNT_W-1:0]  count;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] accNext;
   logic [XLEN-1:0]   opReg;
   logic [2:0]        functReg;
   logic [4:0]        rdReg;
   logic              negAReg;
   logic              negBReg;

   logic              accept;
   logic              negA;
   logic              negB;
   logic [XLEN-1:0]   absA;
   logic [XLEN-1:0]   absB;
   logic              divByZero;
   logic              divOverflow;
   logic              useFast;
   logic [XLEN-1:0]   fastResult;
   logic [2*XLEN-1:0] prodFix;
   logic [XLEN-1:0]   quoFix;
   logic [XLEN-1:0]   remFix;
   logic [XLEN-1:0]   fixResult;

   muldiv_core u_core (
      .divMode (state == MD_DIV),
      .accIn   (acc),
      .operand (opReg),
      .accOut  (accNext)
   );

   // Operand magnitudes and the divide corner cases that bypass iteration.
   always_comb begin
      accept      = (state == MD_IDLE) && StartE && !FlushE;
      negA        = RD1E[XLEN-1] && (FunctE == F3_MULH || FunctE == F3_MULHSU ||
                                     FunctE == F3_DIV  || FunctE == F3_REM);
      negB        = RD2E[XLEN-1] && (FunctE == F3_MULH || FunctE == F3_DIV || FunctE == F3_REM);
      absA        = negA ? -RD1E : RD1E;
      absB        = negB ? -RD2E : RD2E;
      divByZero   = (RD2E == '0);
      divOverflow = (FunctE == F3_DIV || FunctE == F3_REM) &&
                    (RD1E == {1'b1, {(XLEN-1){1'b0}}}) && (RD2E == '1);
      useFast     = FunctE[2] && (divByZero || divOverflow);
      if (divByZero) begin
         fastResult = FunctE[1] ? RD1E : '1;
      end else begin
         fastResult = FunctE[1] ? '0 : RD1E;
      end
      BusyE = RST && ((state == MD_MUL) || (state == MD_DIV) || (state == MD_FIX) || accept);
   end

   // Remainder follows the dividend's sign; quotient and product follow the XOR.
   always_comb begin
      prodFix = (negAReg ^ negBReg) ? -acc : acc;
      quoFix  = (negAReg ^ negBReg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      remFix  = negAReg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (!functReg[2]) begin
         fixResult = (functReg == F3_MUL) ? prodFix[XLEN-1:0] : prodFix[2*XLEN-1:XLEN];
      end else begin
         fixResult = functReg[1] ? remFix : quoFix;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= MD_IDLE;
         count    <= '0;
         acc      <= '0;
         opReg    <= '0;
         functReg <= '0;
         rdReg    <= '0;
         negAReg  <= 1'b0;
         negBReg  <= 1'b0;
         DoneE    <= 1'b0;
         ResultE  <= '0;
         RdOutE   <= '0;
      end else begin
         DoneE <= 1'b0;
         case (state)
            MD_IDLE: begin
               if (accept) begin
                  functReg <= FunctE;
                  rdReg    <= RdE;
                  negAReg  <= negA;
                  negBReg  <= negB;
                  count    <= CNT_W'(XLEN);
                  acc      <= {{XLEN{1'b0}}, (FunctE[2] ? absA : absB)};
                  opReg    <= FunctE[2] ? absB : absA;
                  if (useFast) begin
                     state   <= MD_DONE;
                     DoneE   <= 1'b1;
                     ResultE <= fastResult;
                     RdOutE  <= RdE;
                  end else begin
                     state <= FunctE[2] ? MD_DIV : MD_MUL;
                  end
               end
            end
            MD_MUL, MD_DIV: begin
               if (FlushE) begin
                  state <= MD_IDLE;
               end else begin
                  acc   <= accNext;
                  count <= count - 1'b1;
                  if (count == CNT_W'(1)) begin
                     state <= MD_FIX;
                  end
               end
            end
            MD_FIX: begin
               if (FlushE) begin
                  state <= MD_IDLE;
               end else begin
                  state   <= MD_DONE;
                  DoneE   <= 1'b1;
                  ResultE <= fixResult;
                  RdOutE  <= rdReg;
               end
            end
            MD_DONE: state <= MD_IDLE;
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;
   import riscv_pkg::*;

   logic        CLK;
   logic        RST;
   logic        StartE;
   logic [2:0]  FunctE;
   logic [31:0] RD1E;
   logic [31:0] RD2E;
   logic [4:0]  RdE;
   logic        FlushE;
   logic        BusyE;
   logic        DoneE;
   logic [31:0] ResultE;
   logic [4:0]  RdOutE;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          lat;
      logic [31:0] res;
      logic [4:0]  rd;
      logic        busyOk;
      logic        busyDone;
      logic        doneAfter;
   } obs_t;

   ex_muldiv_unit dut (
      .CLK     (CLK),
      .RST     (RST),
      .StartE  (StartE),
      .FunctE  (FunctE),
      .RD1E    (RD1E),
      .RD2E    (RD2E),
      .RdE     (RdE),
      .FlushE  (FlushE),
      .BusyE   (BusyE),
      .DoneE   (DoneE),
      .ResultE (ResultE),
      .RdOutE  (RdOutE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference: RISC-V M semantics via 64-bit and native integer arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint pa;
      longint pb;
      longint prod;
      int     sa;
      int     sb;
      logic [63:0] pbits;
      if (f < 3'd4) begin
         pa    = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
         pb    = (f == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
         prod  = pa * pb;
         pbits = prod;
         return (f == 3'd0) ? pbits[31:0] : pbits[63:32];
      end
      if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
      if (f == 3'd4 || f == 3'd6) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (f == 3'd6) ? 32'h0 : a;
         sa = a;
         sb = b;
         return (f == 3'd4) ? sa / sb : sa % sb;
      end
      return (f == 3'd5) ? a / b : a % b;
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f >= 3'd4 && (b == 32'h0 ||
          ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 34;
   endfunction

   // Called at a falling edge (cycle t0); returns at the falling edge of t1.
   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      FunctE = f;
      RD1E   = a;
      RD2E   = b;
      RdE    = rd;
      StartE = 1'b1;
      #1;
      checks++;
      if (BusyE !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_t0: BusyE=%b expected 1", BusyE);
      end
      @(negedge CLK);
      StartE = 1'b0;
   endtask

   task automatic wait_done(input int startCyc, input int maxCyc, output int lat,
                            output logic busyOk);
      lat    = startCyc;
      busyOk = 1'b1;
      while (DoneE !== 1'b1 && lat < maxCyc) begin
         if (BusyE !== 1'b1) busyOk = 1'b0;
         @(negedge CLK);
         lat++;
      end
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output obs_t o);
      start_op(f, a, b, rd);
      wait_done(1, 60, o.lat, o.busyOk);
      o.res      = ResultE;
      o.rd       = RdOutE;
      o.busyDone = BusyE;
      @(negedge CLK);
      o.doneAfter = DoneE;
   endtask

   task automatic test_reset();
      RST    = 1'b0;
      StartE = 1'b1;
      FunctE = F3_MUL;
      RD1E   = 32'h5;
      RD2E   = 32'h6;
      RdE    = 5'd3;
      FlushE = 1'b0;
      repeat (2) @(negedge CLK);
      checks++;
      if (BusyE !== 1'b0 || DoneE !== 1'b0 || ResultE !== 32'h0 || RdOutE !== 5'h0) begin
         errors++;
         $display("[TB] FAIL reset_state: Busy=%b Done=%b Result=%h Rd=%h expected all 0",
                  BusyE, DoneE, ResultE, RdOutE);
      end
      StartE = 1'b0;
      RST    = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_mul_basic();
      obs_t o;
      run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, o);
      checks++;
      if (o.res !== 32'hFFFF_FFEB || o.rd !== 5'd5) begin
         errors++;
         $display("[TB] FAIL mul_basic_result: got %h rd %0d expected ffffffeb rd 5", o.res, o.rd);
      end
      checks++;
      if (o.lat != 34 || o.busyOk !== 1'b1 || o.busyDone !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mul_basic_timing: done at t%0d busyOk=%b busyAtDone=%b expected t34 1 0",
                  o.lat, o.busyOk, o.busyDone);
      end
      checks++;
      if (o.doneAfter !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mul_basic_pulse: DoneE after done=%b expected 0", o.doneAfter);
      end
   endtask

   task automatic test_mul_family();
      logic [2:0]  fs  [4];
      logic [31:0] exp [4];
      obs_t o;
      fs  = '{F3_MULHU, F3_MULH, F3_MULHSU, F3_MUL};
      exp = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h1};
      for (int i = 0; i < 4; i++) begin
         run_op(fs[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i + 1), o);
         checks++;
         if (o.res !== exp[i] || o.lat != 34) begin
            errors++;
            $display("[TB] FAIL mul_family f%0d: got %h at t%0d expected %h at t34",
                     fs[i], o.res, o.lat, exp[i]);
         end
      end
   endtask

   task automatic test_div_family();
      logic [2:0]  fs  [4];
      logic [31:0] as  [4];
      logic [31:0] bs  [4];
      logic [31:0] exp [4];
      obs_t o;
      fs  = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
      as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      bs  = '{32'd2, 32'd2, 32'd7, 32'd7};
      exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      for (int i = 0; i < 4; i++) begin
         run_op(fs[i], as[i], bs[i], 5'(i + 10), o);
         checks++;
         if (o.res !== exp[i] || o.lat != 34 || o.rd !== 5'(i + 10)) begin
            errors++;
            $display("[TB] FAIL div_family f%0d: got %h at t%0d rd %0d expected %h at t34 rd %0d",
                     fs[i], o.res, o.lat, o.rd, exp[i], i + 10);
         end
      end
   endtask

   task automatic test_div_fast();
      logic [2:0]  fs  [4];
      logic [31:0] as  [4];
      logic [31:0] bs  [4];
      logic [31:0] exp [4];
      obs_t o;
      fs  = '{F3_DIV, F3_REM, F3_DIV, F3_REM};
      as  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      bs  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      exp = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
      for (int i = 0; i < 4; i++) begin
         run_op(fs[i], as[i], bs[i], 5'(i + 20), o);
         checks++;
         if (o.res !== exp[i] || o.lat != 1 || o.busyDone !== 1'b0 || o.doneAfter !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div_fast case%0d: got %h at t%0d busy=%b next=%b expected %h at t1 0 0",
                     i, o.res, o.lat, o.busyDone, o.doneAfter, exp[i]);
         end
      end
   endtask

   task automatic test_flush();
      logic sawDone;
      int   lat;
      logic busyOk;
      obs_t o;
      sawDone = 1'b0;
      start_op(F3_DIVU, 32'd1000, 32'd3, 5'd4);
      for (int t = 1; t < 10; t++) begin
         if (DoneE !== 1'b0) sawDone = 1'b1;
         @(negedge CLK);
      end
      FlushE = 1'b1;
      #1;
      checks++;
      if (BusyE !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_busy_t10: BusyE=%b expected 1", BusyE);
      end
      @(negedge CLK);
      FlushE = 1'b0;
      #1;
      if (DoneE !== 1'b0) sawDone = 1'b1;
      checks++;
      if (BusyE !== 1'b0 || sawDone !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_idle_t11: BusyE=%b sawDone=%b expected 0 0", BusyE, sawDone);
      end
      @(negedge CLK);
      run_op(F3_DIVU, 32'd1000, 32'd3, 5'd6, o);
      checks++;
      if (o.res !== 32'd333 || o.rd !== 5'd6 || o.lat != 34) begin
         errors++;
         $display("[TB] FAIL flush_restart: got %0d rd %0d at t%0d expected 333 rd 6 at t34",
                  o.res, o.rd, o.lat);
      end

      start_op(F3_MUL, 32'd6, 32'd7, 5'd3);
      repeat (4) @(negedge CLK);
      FunctE = F3_DIVU;
      RD1E   = 32'd9;
      RD2E   = 32'd0;
      RdE    = 5'd20;
      StartE = 1'b1;
      @(negedge CLK);
      StartE = 1'b0;
      wait_done(6, 60, lat, busyOk);
      checks++;
      if (ResultE !== 32'd42 || RdOutE !== 5'd3 || lat != 34) begin
         errors++;
         $display("[TB] FAIL ignore_start: got %0d rd %0d at t%0d expected 42 rd 3 at t34",
                  ResultE, RdOutE, lat);
      end
      sawDone = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge CLK);
         if (DoneE !== 1'b0) sawDone = 1'b1;
      end
      checks++;
      if (sawDone !== 1'b0) begin
         errors++;
         $display("[TB] FAIL spurious_done: DoneE seen=%b expected 0", sawDone);
      end
   endtask

   task automatic test_reset_midop();
      obs_t o;
      start_op(F3_MUL, 32'h0001_2345, 32'h0000_0777, 5'd11);
      repeat (4) @(negedge CLK);
      RST    = 1'b0;
      StartE = 1'b1;
      #1;
      checks++;
      if (BusyE !== 1'b0 || DoneE !== 1'b0 || ResultE !== 32'h0 || RdOutE !== 5'h0) begin
         errors++;
         $display("[TB] FAIL reset_midop: Busy=%b Done=%b Result=%h Rd=%h expected all 0",
                  BusyE, DoneE, ResultE, RdOutE);
      end
      @(negedge CLK);
      StartE = 1'b0;
      RST    = 1'b1;
      @(negedge CLK);
      run_op(F3_MUL, 32'd3, 32'd4, 5'd9, o);
      checks++;
      if (o.res !== 32'd12 || o.rd !== 5'd9 || o.lat != 34) begin
         errors++;
         $display("[TB] FAIL reset_recover: got %0d rd %0d at t%0d expected 12 rd 9 at t34",
                  o.res, o.rd, o.lat);
      end
   endtask

   task automatic test_random();
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      obs_t        o;
      for (int i = 0; i < 40; i++) begin
         f  = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         rd = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 9))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'h0;
            default: ;
         endcase
         run_op(f, a, b, rd, o);
         checks++;
         if (o.res !== ref_result(f, a, b) || o.rd !== rd || o.lat != ref_latency(f, a, b)) begin
            errors++;
            $display("[TB] FAIL random%0d f%0d a=%h b=%h: got %h rd %0d t%0d expected %h rd %0d t%0d",
                     i, f, a, b, o.res, o.rd, o.lat, ref_result(f, a, b), rd, ref_latency(f, a, b));
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_mul_family();
      test_div_family();
      test_div_fast();
      test_flush();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
